aer_tx_arbiter: RTL and testbench

- Sits between the tinyODIN output AER port, the configuration readback source and the UART transmit AXI stream.
- Accepts spike addresses from the core via a 4-phase req/ack handshake and buffers them in a FIFO.
- Accepts 16-bit readback words via a valid/ready handshake.
- Round-robin arbitrates between the two sources and serialises each event as a framed byte sequence, so the host can tell spikes from readback data.

---
 rtl/aer_tx_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_aer_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aer_tx_arbiter.sv
// rtl/aer_tx_arbiter.sv - spike/readback arbiter framing events onto a byte stream
module aer_tx_arbiter #(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [7:0]  HDR_SPIKE  = 8'hF0,
    parameter logic [7:0]  HDR_RB     = 8'hF1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    aer_addr,
    input  logic                          aer_req,
    output logic                          aer_ack,
    input  logic [15:0]                   rb_data,
    input  logic                          rb_valid,
    output logic                          rb_ready,
    output logic [7:0]                    m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          fifo_full
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] LVL_ONE = LW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // AER handshake states
    localparam logic A_IDLE = 1'b0;
    localparam logic A_WAIT = 1'b1;

    // Transmit framing states
    localparam logic [2:0] TX_IDLE     = 3'd0;
    localparam logic [2:0] TX_SPK_HDR  = 3'd1;
    localparam logic [2:0] TX_SPK_ADDR = 3'd2;
    localparam logic [2:0] TX_RB_HDR   = 3'd3;
    localparam logic [2:0] TX_RB_HI    = 3'd4;
    localparam logic [2:0] TX_RB_LO    = 3'd5;

    logic            a_state;
    logic [2:0]      tx_state;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [LW-1:0]   level_next;

    logic [7:0]      spk_byte;
    logic [15:0]     rb_word;
    logic            last_grant_rb;

    logic            push;
    logic            pop;
    logic            spk_pend;
    logic            grant_spk;
    logic            grant_rb;

    // Push/pop strobes, round-robin grant and next FIFO occupancy
    always_comb begin
        push      = (a_state == A_IDLE) && aer_req && !fifo_full;
        spk_pend  = (fifo_level != '0);
        grant_spk = (tx_state == TX_IDLE) && spk_pend && (!rb_valid || last_grant_rb);
        grant_rb  = (tx_state == TX_IDLE) && rb_valid && (!spk_pend || !last_grant_rb);
        pop       = grant_spk;
        level_next = fifo_level;
        case ({push, pop})
            2'b10:   level_next = fifo_level + LVL_ONE;
            2'b01:   level_next = fifo_level - LVL_ONE;
            default: level_next = fifo_level;
        endcase
    end

    // 4-phase acknowledge: a full FIFO simply withholds ack, stalling the core
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state <= A_IDLE;
            aer_ack <= 1'b0;
        end else begin
            case (a_state)
                A_IDLE: begin
                    if (push) begin
                        aer_ack <= 1'b1;
                        a_state <= A_WAIT;
                    end
                end
                default: begin
                    if (!aer_req) begin
                        aer_ack <= 1'b0;
                        a_state <= A_IDLE;
                    end
                end
            endcase
        end
    end

    // Spike storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= aer_addr;
        end
    end

    // FIFO pointers and occupancy flags, all updated on the push/pop edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            fifo_full  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            fifo_level <= level_next;
            fifo_full  <= (level_next == DEPTH_L);
        end
    end

    // Frame serialiser: each byte is held until accepted, frames never interleave
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state      <= TX_IDLE;
            m_axis_tdata  <= 8'h00;
            m_axis_tvalid <= 1'b0;
            rb_ready      <= 1'b0;
            spk_byte      <= 8'h00;
            rb_word       <= 16'h0000;
            last_grant_rb <= 1'b1;
        end else begin
            rb_ready <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (grant_spk) begin
                        spk_byte      <= mem[rd_ptr];
                        m_axis_tdata  <= HDR_SPIKE;
                        m_axis_tvalid <= 1'b1;
                        last_grant_rb <= 1'b0;
                        tx_state      <= TX_SPK_HDR;
                    end else if (grant_rb) begin
                        rb_word       <= rb_data;
                        rb_ready      <= 1'b1;
                        m_axis_tdata  <= HDR_RB;
                        m_axis_tvalid <= 1'b1;
                        last_grant_rb <= 1'b1;
                        tx_state      <= TX_RB_HDR;
                    end
                end
                TX_SPK_HDR: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= spk_byte;
                        tx_state     <= TX_SPK_ADDR;
                    end
                end
                TX_SPK_ADDR: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        tx_state      <= TX_IDLE;
                    end
                end
                TX_RB_HDR: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= rb_word[15:8];
                        tx_state     <= TX_RB_HI;
                    end
                end
                TX_RB_HI: begin
                    if (m_axis_tready) begin
                        m_axis_tdata <= rb_word[7:0];
                        tx_state     <= TX_RB_LO;
                    end
                end
                TX_RB_LO: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        tx_state      <= TX_IDLE;
                    end
                end
                default: begin
                    m_axis_tvalid <= 1'b0;
                    tx_state      <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aer_tx_arbiter.sv
// tb/tb_aer_tx_arbiter.sv - directed self-checking bench for aer_tx_arbiter
module tb_aer_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  aer_addr;
    logic        aer_req;
    logic        aer_ack;
    logic [15:0] rb_data;
    logic        rb_valid;
    logic        rb_ready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [4:0]  fifo_level;
    logic        fifo_full;

    int passed;
    int total;

    aer_tx_arbiter #(.FIFO_DEPTH(16), .HDR_SPIKE(8'hF0), .HDR_RB(8'hF1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .aer_addr      (aer_addr),
        .aer_req       (aer_req),
        .aer_ack       (aer_ack),
        .rb_data       (rb_data),
        .rb_valid      (rb_valid),
        .rb_ready      (rb_ready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fifo_level    (fifo_level),
        .fifo_full     (fifo_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // one active edge, then return at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] exp_bytes [$];
        int idx;
        int budget;

        passed = 0;
        total  = 0;
        rst_n = 1'b0;
        aer_addr = 8'h00;
        aer_req = 1'b0;
        rb_data = 16'h0000;
        rb_valid = 1'b0;
        m_axis_tready = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ack", aer_ack, 0);
        chk("rst_rb_ready", rb_ready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 8'h00);
        chk("rst_level", fifo_level, 0);
        chk("rst_full", fifo_full, 0);
        rst_n = 1'b1;
        tick();

        // single spike 0x3C
        m_axis_tready = 1'b1;
        aer_addr = 8'h3C;
        aer_req = 1'b1;
        tick();
        chk("sp_ack_rise", aer_ack, 1);
        chk("sp_level1", fifo_level, 1);
        chk("sp_tvalid0", m_axis_tvalid, 0);
        aer_req = 1'b0;
        tick();
        chk("sp_ack_fall", aer_ack, 0);
        chk("sp_hdr_valid", m_axis_tvalid, 1);
        chk("sp_hdr", m_axis_tdata, 8'hF0);
        chk("sp_level0", fifo_level, 0);
        tick();
        chk("sp_addr", m_axis_tdata, 8'h3C);
        chk("sp_addr_valid", m_axis_tvalid, 1);
        tick();
        chk("sp_idle", m_axis_tvalid, 0);

        // readback 0xBEEF
        rb_data = 16'hBEEF;
        rb_valid = 1'b1;
        tick();
        chk("rb_ready_pulse", rb_ready, 1);
        chk("rb_hdr", m_axis_tdata, 8'hF1);
        chk("rb_hdr_valid", m_axis_tvalid, 1);
        rb_valid = 1'b0;
        rb_data = 16'h0000;
        tick();
        chk("rb_ready_low", rb_ready, 0);
        chk("rb_hi", m_axis_tdata, 8'hBE);
        tick();
        chk("rb_lo", m_axis_tdata, 8'hEF);
        tick();
        chk("rb_idle", m_axis_tvalid, 0);

        // backpressure during the high byte
        rb_data = 16'hBEEF;
        rb_valid = 1'b1;
        tick();
        chk("bp_hdr", m_axis_tdata, 8'hF1);
        rb_valid = 1'b0;
        tick();
        chk("bp_hi", m_axis_tdata, 8'hBE);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold_data", m_axis_tdata, 8'hBE);
            chk("bp_hold_valid", m_axis_tvalid, 1);
        end
        m_axis_tready = 1'b1;
        tick();
        chk("bp_lo", m_axis_tdata, 8'hEF);
        tick();
        chk("bp_idle", m_axis_tvalid, 0);

        // full FIFO: a stalled readback frame keeps the serialiser busy
        m_axis_tready = 1'b0;
        rb_data = 16'hA55A;
        rb_valid = 1'b1;
        tick();
        chk("ff_rb_hdr", m_axis_tdata, 8'hF1);
        rb_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            aer_addr = 8'(i);
            aer_req = 1'b1;
            tick();
            chk("ff_push_ack", aer_ack, 1);
            chk("ff_push_level", fifo_level, 32'(i + 1));
            aer_req = 1'b0;
            tick();
        end
        chk("ff_full", fifo_full, 1);
        aer_addr = 8'h10;
        aer_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ff_blocked_ack", aer_ack, 0);
            chk("ff_blocked_full", fifo_full, 1);
            chk("ff_blocked_level", fifo_level, 16);
        end
        m_axis_tready = 1'b1;
        tick();
        chk("ff_rb_hi", m_axis_tdata, 8'hA5);
        tick();
        chk("ff_rb_lo", m_axis_tdata, 8'h5A);
        tick();
        chk("ff_rb_idle", m_axis_tvalid, 0);
        tick();
        chk("ff_pop_hdr", m_axis_tdata, 8'hF0);
        chk("ff_pop_level", fifo_level, 15);
        chk("ff_pop_notfull", fifo_full, 0);
        chk("ff_pop_ack", aer_ack, 0);
        tick();
        chk("ff_late_ack", aer_ack, 1);
        chk("ff_late_level", fifo_level, 16);
        chk("ff_addr0", m_axis_tdata, 8'h00);
        aer_req = 1'b0;
        tick();
        for (int k = 1; k <= 16; k++) begin
            exp_bytes.push_back(8'hF0);
            exp_bytes.push_back(8'(k));
        end
        idx = 0;
        budget = 0;
        while (idx < exp_bytes.size() && budget < 200) begin
            if (m_axis_tvalid) begin
                chk("ff_drain_byte", m_axis_tdata, exp_bytes[idx]);
                idx++;
            end
            tick();
            budget++;
        end
        chk("ff_drain_count", idx, exp_bytes.size());
        chk("ff_drain_level", fifo_level, 0);
        chk("ff_drain_ack", aer_ack, 0);

        // asynchronous reset while the address byte is pending
        aer_addr = 8'h77;
        aer_req = 1'b1;
        tick();
        aer_req = 1'b0;
        tick();
        chk("mr_hdr", m_axis_tdata, 8'hF0);
        aer_addr = 8'h78;
        aer_req = 1'b1;
        tick();
        chk("mr_addr", m_axis_tdata, 8'h77);
        chk("mr_ack_high", aer_ack, 1);
        chk("mr_level", fifo_level, 1);
        m_axis_tready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_tvalid", m_axis_tvalid, 0);
        chk("mr_ack", aer_ack, 0);
        chk("mr_level0", fifo_level, 0);
        chk("mr_tdata", m_axis_tdata, 8'h00);
        aer_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        tick();

        // round robin after reset: spike wins first tie, readback wins the next
        aer_addr = 8'h22;
        aer_req = 1'b1;
        tick();
        chk("rr_push1", fifo_level, 1);
        aer_req = 1'b0;
        rb_data = 16'hCAFE;
        rb_valid = 1'b1;
        tick();
        chk("rr_tie1_hdr", m_axis_tdata, 8'hF0);
        chk("rr_tie1_rbready", rb_ready, 0);
        aer_addr = 8'h33;
        aer_req = 1'b1;
        tick();
        chk("rr_spk1_addr", m_axis_tdata, 8'h22);
        chk("rr_push2", fifo_level, 1);
        aer_req = 1'b0;
        tick();
        chk("rr_gap1", m_axis_tvalid, 0);
        tick();
        chk("rr_tie2_hdr", m_axis_tdata, 8'hF1);
        chk("rr_tie2_rbready", rb_ready, 1);
        chk("rr_tie2_level", fifo_level, 1);
        rb_valid = 1'b0;
        tick();
        chk("rr_rb_hi", m_axis_tdata, 8'hCA);
        tick();
        chk("rr_rb_lo", m_axis_tdata, 8'hFE);
        tick();
        chk("rr_gap2", m_axis_tvalid, 0);
        tick();
        chk("rr_spk2_hdr", m_axis_tdata, 8'hF0);
        chk("rr_spk2_level", fifo_level, 0);
        tick();
        chk("rr_spk2_addr", m_axis_tdata, 8'h33);
        tick();
        chk("rr_end_idle", m_axis_tvalid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
